// File: rtl/bus_pkg.sv
// bus_pkg: shared types and constants for the 1-to-2 data bus demux.
// Holds the FSM state encoding and region-decode defaults.
package bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_RSP,
    ST_RESP
  } bus_state_e;

  localparam logic [31:0] B_BASE_DEF = 32'h1000_0000;
  localparam logic [31:0] B_MASK_DEF = 32'hF000_0000;
  localparam logic [31:0] ERR_RDATA  = 32'hDEAD_BEEF;
  localparam int unsigned CNT_W      = 16;

endpackage

// File: rtl/bus_timeout_ctr.sv
// bus_timeout_ctr: watchdog cycle counter for a bus transaction.
// expired flags the cycle that completes limit enabled cycles.
module bus_timeout_ctr
  import bus_pkg::*;
#(
  parameter int unsigned W = CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] limit,
  output logic         expired
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear wins, otherwise count enabled cycles.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  assign expired = enable && (cnt_q == limit - W'(1));

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/bus_demux_1to2.sv
// bus_demux_1to2: routes one core bus transaction to RAM (A) or MMIO (B).
// Define BUS_TIMEOUT_EN to build the response watchdog.
module bus_demux_1to2
  import bus_pkg::*;
#(
  parameter int unsigned      DATA_W         = 32,
  parameter logic [DATA_W-1:0] B_BASE        = B_BASE_DEF,
  parameter logic [DATA_W-1:0] B_MASK        = B_MASK_DEF,
  parameter int unsigned      TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m_req_valid,
  output logic              m_req_ready,
  input  logic [DATA_W-1:0] m_req_addr,
  input  logic              m_req_we,
  input  logic [DATA_W-1:0] m_req_wdata,
  input  logic [3:0]        m_req_wstrb,
  output logic              m_rsp_valid,
  output logic [DATA_W-1:0] m_rsp_rdata,
  output logic              m_rsp_err,
  output logic              a_req_valid,
  input  logic              a_req_ready,
  output logic [DATA_W-1:0] a_req_addr,
  output logic              a_req_we,
  output logic [DATA_W-1:0] a_req_wdata,
  output logic [3:0]        a_req_wstrb,
  input  logic              a_rsp_valid,
  input  logic [DATA_W-1:0] a_rsp_rdata,
  output logic              b_req_valid,
  input  logic              b_req_ready,
  output logic [DATA_W-1:0] b_req_addr,
  output logic              b_req_we,
  output logic [DATA_W-1:0] b_req_wdata,
  output logic [3:0]        b_req_wstrb,
  input  logic              b_rsp_valid,
  input  logic [DATA_W-1:0] b_rsp_rdata
);

  bus_state_e        state_q, state_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic              sel_b_q, sel_b_d;
  logic              a_valid_q, a_valid_d;
  logic              b_valid_q, b_valid_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              timeout;

  logic              tgt_ready;
  logic              tgt_rsp;
  logic [DATA_W-1:0] tgt_rdata;

  assign tgt_ready = sel_b_q ? b_req_ready : a_req_ready;
  assign tgt_rsp   = sel_b_q ? b_rsp_valid : a_rsp_valid;
  assign tgt_rdata = sel_b_q ? b_rsp_rdata : a_rsp_rdata;

`ifdef BUS_TIMEOUT_EN
  logic to_clear;
  logic to_en;

  assign to_clear = (state_q == ST_IDLE) && m_req_valid;
  assign to_en    = (state_q == ST_ISSUE) ||
                    (state_q == ST_WAIT_RSP);

  bus_timeout_ctr #(
    .W(CNT_W)
  ) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (to_clear),
    .enable (to_en),
    .limit  (CNT_W'(TIMEOUT_CYCLES)),
    .expired(timeout)
  );
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = |TIMEOUT_CYCLES;
  assign timeout            = 1'b0;
`endif

  // Transaction FSM next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    sel_b_d     = sel_b_q;
    a_valid_d   = a_valid_q;
    b_valid_d   = b_valid_q;
    rsp_valid_d = rsp_valid_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (m_req_valid) begin
          addr_d    = m_req_addr;
          we_d      = m_req_we;
          wdata_d   = m_req_wdata;
          wstrb_d   = m_req_wstrb;
          sel_b_d   = (m_req_addr & B_MASK) == B_BASE;
          a_valid_d = !sel_b_d;
          b_valid_d = sel_b_d;
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (timeout) begin
          a_valid_d   = 1'b0;
          b_valid_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rdata_d     = DATA_W'(ERR_RDATA);
          err_d       = 1'b1;
          state_d     = ST_RESP;
        end else if (tgt_ready) begin
          a_valid_d = 1'b0;
          b_valid_d = 1'b0;
          state_d   = ST_WAIT_RSP;
        end
      end
      ST_WAIT_RSP: begin
        if (tgt_rsp) begin
          rsp_valid_d = 1'b1;
          rdata_d     = we_q ? '0 : tgt_rdata;
          state_d     = ST_RESP;
        end else if (timeout) begin
          rsp_valid_d = 1'b1;
          rdata_d     = DATA_W'(ERR_RDATA);
          err_d       = 1'b1;
          state_d     = ST_RESP;
        end
      end
      ST_RESP: begin
        rsp_valid_d = 1'b0;
        rdata_d     = '0;
        err_d       = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // State and request/response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      sel_b_q     <= 1'b0;
      a_valid_q   <= 1'b0;
      b_valid_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      sel_b_q     <= sel_b_d;
      a_valid_q   <= a_valid_d;
      b_valid_q   <= b_valid_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  assign m_req_ready = (state_q == ST_IDLE);
  assign m_rsp_valid = rsp_valid_q;
  assign m_rsp_rdata = rdata_q;
`ifdef BUS_TIMEOUT_EN
  assign m_rsp_err   = err_q;
`else
  assign m_rsp_err   = 1'b0;
`endif

  assign a_req_valid = a_valid_q;
  assign a_req_addr  = addr_q;
  assign a_req_we    = we_q;
  assign a_req_wdata = wdata_q;
  assign a_req_wstrb = wstrb_q;
  assign b_req_valid = b_valid_q;
  assign b_req_addr  = addr_q;
  assign b_req_we    = we_q;
  assign b_req_wdata = wdata_q;
  assign b_req_wstrb = wstrb_q;

endmodule

// File: tb/tb_bus_demux_1to2.sv
// tb_bus_demux_1to2: directed bench for the 1-to-2 bus demux.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_bus_demux_1to2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m_req_valid = 1'b0;
  logic        m_req_ready;
  logic [31:0] m_req_addr = '0;
  logic        m_req_we = 1'b0;
  logic [31:0] m_req_wdata = '0;
  logic [3:0]  m_req_wstrb = '0;
  logic        m_rsp_valid;
  logic [31:0] m_rsp_rdata;
  logic        m_rsp_err;
  logic        a_req_valid;
  logic        a_req_ready = 1'b0;
  logic [31:0] a_req_addr;
  logic        a_req_we;
  logic [31:0] a_req_wdata;
  logic [3:0]  a_req_wstrb;
  logic        a_rsp_valid = 1'b0;
  logic [31:0] a_rsp_rdata = '0;
  logic        b_req_valid;
  logic        b_req_ready = 1'b0;
  logic [31:0] b_req_addr;
  logic        b_req_we;
  logic [31:0] b_req_wdata;
  logic [3:0]  b_req_wstrb;
  logic        b_rsp_valid = 1'b0;
  logic [31:0] b_rsp_rdata = '0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  bus_demux_1to2 #(
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .m_req_valid(m_req_valid), .m_req_ready(m_req_ready),
    .m_req_addr(m_req_addr), .m_req_we(m_req_we),
    .m_req_wdata(m_req_wdata), .m_req_wstrb(m_req_wstrb),
    .m_rsp_valid(m_rsp_valid), .m_rsp_rdata(m_rsp_rdata),
    .m_rsp_err(m_rsp_err),
    .a_req_valid(a_req_valid), .a_req_ready(a_req_ready),
    .a_req_addr(a_req_addr), .a_req_we(a_req_we),
    .a_req_wdata(a_req_wdata), .a_req_wstrb(a_req_wstrb),
    .a_rsp_valid(a_rsp_valid), .a_rsp_rdata(a_rsp_rdata),
    .b_req_valid(b_req_valid), .b_req_ready(b_req_ready),
    .b_req_addr(b_req_addr), .b_req_we(b_req_we),
    .b_req_wdata(b_req_wdata), .b_req_wstrb(b_req_wstrb),
    .b_rsp_valid(b_rsp_valid), .b_rsp_rdata(b_rsp_rdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    total++;
    if ({m_rsp_valid, m_rsp_rdata, m_rsp_err} !== 34'd0) begin
      bad++;
      $display("FAIL reset_rsp: got v=%b d=%h e=%b want 0",
               m_rsp_valid, m_rsp_rdata, m_rsp_err);
    end
    total++;
    if ({a_req_valid, b_req_valid, a_req_addr, a_req_we,
         a_req_wdata, a_req_wstrb} !== 71'd0) begin
      bad++;
      $display("FAIL reset_req: got av=%b bv=%b addr=%h want 0",
               a_req_valid, b_req_valid, a_req_addr);
    end
    total++;
    if (m_req_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready: got %b want 1", m_req_ready);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_load();
    a_req_ready = 1'b1;
    m_req_valid = 1'b1;
    m_req_addr  = 32'h0000_0040;
    m_req_we    = 1'b0;
    total++;
    if (m_req_ready !== 1'b1) begin
      bad++;
      $display("FAIL load_ready: got %b want 1", m_req_ready);
    end
    tick();
    m_req_valid = 1'b0;
    total++;
    if ({a_req_valid, b_req_valid, a_req_addr, a_req_we} !==
        {1'b1, 1'b0, 32'h0000_0040, 1'b0}) begin
      bad++;
      $display("FAIL load_issue: got av=%b bv=%b addr=%h we=%b",
               a_req_valid, b_req_valid, a_req_addr, a_req_we);
    end
    tick();
    a_rsp_valid = 1'b1;
    a_rsp_rdata = 32'h1234_5678;
    total++;
    if ({a_req_valid, b_req_valid, m_rsp_valid} !== 3'b000) begin
      bad++;
      $display("FAIL load_wait: got av=%b bv=%b rv=%b want 000",
               a_req_valid, b_req_valid, m_rsp_valid);
    end
    tick();
    a_rsp_valid = 1'b0;
    total++;
    if ({m_rsp_valid, m_rsp_rdata, m_rsp_err, b_req_valid} !==
        {1'b1, 32'h1234_5678, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL load_rsp: got v=%b d=%h e=%b bv=%b",
               m_rsp_valid, m_rsp_rdata, m_rsp_err, b_req_valid);
    end
    tick();
    total++;
    if ({m_rsp_valid, m_req_ready} !== 2'b01) begin
      bad++;
      $display("FAIL load_done: got rv=%b rdy=%b want 0 1",
               m_rsp_valid, m_req_ready);
    end
    a_req_ready = 1'b0;
  endtask

  task automatic test_store();
    b_req_ready = 1'b1;
    m_req_valid = 1'b1;
    m_req_addr  = 32'h1000_0004;
    m_req_we    = 1'b1;
    m_req_wdata = 32'hCAFE_F00D;
    m_req_wstrb = 4'b0011;
    tick();
    m_req_valid = 1'b0;
    m_req_we    = 1'b0;
    total++;
    if ({b_req_valid, a_req_valid, b_req_addr, b_req_we,
         b_req_wdata, b_req_wstrb} !==
        {1'b1, 1'b0, 32'h1000_0004, 1'b1,
         32'hCAFE_F00D, 4'b0011}) begin
      bad++;
      $display("FAIL store_issue: got bv=%b av=%b a=%h we=%b d=%h s=%b",
               b_req_valid, a_req_valid, b_req_addr, b_req_we,
               b_req_wdata, b_req_wstrb);
    end
    tick();
    b_rsp_valid = 1'b1;
    b_rsp_rdata = 32'hFFFF_FFFF;
    tick();
    b_rsp_valid = 1'b0;
    total++;
    if ({m_rsp_valid, m_rsp_rdata, m_rsp_err} !==
        {1'b1, 32'h0, 1'b0}) begin
      bad++;
      $display("FAIL store_rsp: got v=%b d=%h e=%b want 1 0 0",
               m_rsp_valid, m_rsp_rdata, m_rsp_err);
    end
    tick();
    b_req_ready = 1'b0;
  endtask

  task automatic test_stall();
    a_req_ready = 1'b0;
    m_req_valid = 1'b1;
    m_req_addr  = 32'h0000_0080;
    m_req_we    = 1'b0;
    tick();
    m_req_addr  = 32'h1000_0000;
    a_rsp_valid = 1'b1;
    a_rsp_rdata = 32'hBAD0_0001;
    b_rsp_valid = 1'b1;
    b_rsp_rdata = 32'hBAD0_0002;
    for (int i = 0; i < 5; i++) begin
      total++;
      if ({a_req_valid, b_req_valid, a_req_addr, m_req_ready,
           m_rsp_valid} !==
          {1'b1, 1'b0, 32'h0000_0080, 1'b0, 1'b0}) begin
        bad++;
        $display("FAIL stall_hold%0d: av=%b bv=%b a=%h rdy=%b rv=%b",
                 i, a_req_valid, b_req_valid, a_req_addr,
                 m_req_ready, m_rsp_valid);
      end
      if (i == 4) a_req_ready = 1'b1;
      tick();
    end
    m_req_valid = 1'b0;
    a_rsp_valid = 1'b0;
    b_rsp_valid = 1'b0;
    a_req_ready = 1'b0;
    tick();
    total++;
    if ({m_rsp_valid, a_req_valid, m_req_ready} !== 3'b000) begin
      bad++;
      $display("FAIL stall_norsp: rv=%b av=%b rdy=%b want 000",
               m_rsp_valid, a_req_valid, m_req_ready);
    end
    a_rsp_valid = 1'b1;
    a_rsp_rdata = 32'hAAAA_5555;
    tick();
    a_rsp_valid = 1'b0;
    total++;
    if ({m_rsp_valid, m_rsp_rdata} !== {1'b1, 32'hAAAA_5555}) begin
      bad++;
      $display("FAIL stall_rsp: got v=%b d=%h want 1 aaaa5555",
               m_rsp_valid, m_rsp_rdata);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    a_req_ready = 1'b1;
    b_req_ready = 1'b1;
    m_req_valid = 1'b1;
    m_req_addr  = 32'h0000_0100;
    m_req_we    = 1'b0;
    tick();
    m_req_addr = 32'h1000_0010;
    total++;
    if ({a_req_valid, m_req_ready} !== 2'b10) begin
      bad++;
      $display("FAIL b2b_issue_a: av=%b rdy=%b want 1 0",
               a_req_valid, m_req_ready);
    end
    tick();
    a_rsp_valid = 1'b1;
    a_rsp_rdata = 32'h1111_1111;
    tick();
    a_rsp_valid = 1'b0;
    total++;
    if ({m_rsp_valid, m_rsp_rdata, m_req_ready} !==
        {1'b1, 32'h1111_1111, 1'b0}) begin
      bad++;
      $display("FAIL b2b_rsp_a: v=%b d=%h rdy=%b",
               m_rsp_valid, m_rsp_rdata, m_req_ready);
    end
    tick();
    total++;
    if ({m_req_ready, b_req_valid, m_rsp_valid} !== 3'b100) begin
      bad++;
      $display("FAIL b2b_idle: rdy=%b bv=%b rv=%b want 100",
               m_req_ready, b_req_valid, m_rsp_valid);
    end
    tick();
    m_req_valid = 1'b0;
    total++;
    if ({b_req_valid, a_req_valid, b_req_addr} !==
        {1'b1, 1'b0, 32'h1000_0010}) begin
      bad++;
      $display("FAIL b2b_issue_b: bv=%b av=%b a=%h",
               b_req_valid, a_req_valid, b_req_addr);
    end
    tick();
    b_rsp_valid = 1'b1;
    b_rsp_rdata = 32'h2222_2222;
    tick();
    b_rsp_valid = 1'b0;
    total++;
    if ({m_rsp_valid, m_rsp_rdata} !== {1'b1, 32'h2222_2222}) begin
      bad++;
      $display("FAIL b2b_rsp_b: v=%b d=%h want 1 22222222",
               m_rsp_valid, m_rsp_rdata);
    end
    tick();
    a_req_ready = 1'b0;
    b_req_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    a_req_ready = 1'b1;
    m_req_valid = 1'b1;
    m_req_addr  = 32'h0000_0200;
    tick();
    m_req_valid = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    a_rsp_valid = 1'b1;
    a_rsp_rdata = 32'h5555_AAAA;
    #1;
    total++;
    if ({a_req_valid, b_req_valid, a_req_addr, m_rsp_valid,
         m_rsp_rdata, m_rsp_err, m_req_ready} !==
        {1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL rstmid_async: av=%b a=%h rv=%b d=%h rdy=%b",
               a_req_valid, a_req_addr, m_rsp_valid,
               m_rsp_rdata, m_req_ready);
    end
    tick();
    tick();
    rst_n = 1'b1;
    a_rsp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if ({m_rsp_valid, m_req_ready} !== 2'b01) begin
        bad++;
        $display("FAIL rstmid_quiet%0d: rv=%b rdy=%b want 0 1",
                 i, m_rsp_valid, m_req_ready);
      end
    end
    test_load();
  endtask

`ifdef BUS_TIMEOUT_EN
  task automatic test_timeout();
    a_req_ready = 1'b0;
    m_req_valid = 1'b1;
    m_req_addr  = 32'h0000_0300;
    m_req_we    = 1'b0;
    tick();
    m_req_valid = 1'b0;
    for (int i = 1; i < 8; i++) begin
      total++;
      if ({a_req_valid, m_rsp_valid} !== 2'b10) begin
        bad++;
        $display("FAIL to_wait%0d: av=%b rv=%b want 1 0",
                 i, a_req_valid, m_rsp_valid);
      end
      tick();
    end
    total++;
    if ({a_req_valid, m_rsp_valid, m_rsp_err, m_rsp_rdata} !==
        {1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF}) begin
      bad++;
      $display("FAIL to_err: av=%b v=%b e=%b d=%h",
               a_req_valid, m_rsp_valid, m_rsp_err, m_rsp_rdata);
    end
    a_rsp_valid = 1'b1;
    a_rsp_rdata = 32'h7777_7777;
    tick();
    tick();
    a_rsp_valid = 1'b0;
    total++;
    if ({m_rsp_valid, m_rsp_err, m_req_ready} !== 3'b001) begin
      bad++;
      $display("FAIL to_late: rv=%b e=%b rdy=%b want 001",
               m_rsp_valid, m_rsp_err, m_req_ready);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_load();
    test_store();
    test_stall();
    test_back_to_back();
    test_reset_mid();
`ifdef BUS_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
